// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and default bit timing.
// The same default bit period (25 MHz / 115200) is used by the transmitter.
package uart_rx_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 217;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

endpackage

// File: rtl/uart_rx_shift_reg_sipo.sv
// Serial-in parallel-out shift register, the mirror of the transmit-side PISO.
// Shifts right so the first serial bit ends up at bit 0 after WIDTH shifts.
module shift_reg_sipo #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_shift,
  input  logic             i_serial,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (i_shift) data_d = {i_serial, data_q[WIDTH-1:1]};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) data_q <= '0;
    else         data_q <= data_d;
  end

  assign o_data = data_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling FSM, LSB-first assembly.
// Define UART_RX_PARITY_EN to add an even-parity bit and the o_parity_err output.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_busy,
`ifdef UART_RX_PARITY_EN
  output logic                 o_parity_err,
`endif
  output logic [2:0]           o_dbg_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  logic                 rx_meta_q, rx_s_q;
  state_e               state_d, state_q;
  logic [CW-1:0]        cnt_d, cnt_q;
  logic [IW-1:0]        idx_d, idx_q;
  logic [DATA_BITS-1:0] data_d, data_q;
  logic                 valid_d, valid_q;
  logic                 ferr_d, ferr_q;
  logic                 shift;
  logic [DATA_BITS-1:0] sipo_data;
`ifdef UART_RX_PARITY_EN
  logic                 par_d, par_q;
  logic                 perr_d, perr_q;
`endif

  shift_reg_sipo #(.WIDTH(DATA_BITS)) u_sipo (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_shift  (shift),
    .i_serial (rx_s_q),
    .o_data   (sipo_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    shift   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        // A start bit that is high again at mid-bit was only a glitch.
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          shift = 1'b1;
          idx_d = idx_q + IW'(1);
          if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          par_d   = rx_s_q;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        // A low stop bit wins over any parity result.
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (!rx_s_q) begin
            ferr_d = 1'b1;
          end else begin
`ifdef UART_RX_PARITY_EN
            if ((^sipo_data) != par_q) begin
              perr_d = 1'b1;
            end else begin
              valid_d = 1'b1;
              data_d  = sipo_data;
            end
`else
            valid_d = 1'b1;
            data_d  = sipo_data;
`endif
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_frame_err  = ferr_q;
  assign o_busy       = (state_q != IDLE);
  assign o_dbg_state  = state_q;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CLKS_PER_BIT=16: directed frames, scoreboard of expected pulses.
module tb_uart_rx;

  localparam int CPB = 16;
  localparam logic [1:0] K_VALID = 2'd0;
  localparam logic [1:0] K_FERR  = 2'd1;
  localparam logic [1:0] K_PERR  = 2'd2;

  logic       i_clk;
  logic       i_reset;
  logic       i_rx;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_busy;
  logic       perr;
  logic [2:0] o_dbg_state;

  logic [9:0] exp_q[$];
  int tests;
  int failed;
  int cyc;
  int prev_valid_cyc;
  int last_valid_cyc;
  logic busy_seen;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_rx         (i_rx),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_frame_err  (o_frame_err),
    .o_busy       (o_busy),
`ifdef UART_RX_PARITY_EN
    .o_parity_err (perr),
`endif
    .o_dbg_state  (o_dbg_state)
  );

`ifndef UART_RX_PARITY_EN
  assign perr = 1'b0;
`endif

  // Clock and cycle count
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Driver: every line change happens on a falling edge
  task automatic drive_bit(input logic v);
    i_rx = v;
    repeat (CPB) @(negedge i_clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_bit);
`else
    if (par_bit === 1'bx) $display("[TB] parity bit unknown");
`endif
    drive_bit(stop_bit);
  endtask

  task automatic expect_evt(input logic [1:0] kind, input logic [7:0] data);
    exp_q.push_back({kind, data});
  endtask

  // Monitor / scoreboard
  always @(negedge i_clk) begin
    logic [9:0] e;
    logic [1:0] kind;
    cyc++;
    if (o_busy) busy_seen = 1'b1;
    if (!i_reset && (o_valid || o_frame_err || perr)) begin
      check("pulse_exclusive", {31'd0, (o_valid + o_frame_err + perr) > 2'd1}, 32'd0);
      kind = o_valid ? K_VALID : (o_frame_err ? K_FERR : K_PERR);
      if (o_valid) begin
        prev_valid_cyc = last_valid_cyc;
        last_valid_cyc = cyc;
      end
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_pulse: kind %0d data 0x%0h, expected none (cycle %0d)", kind, o_data, cyc);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", {30'd0, kind}, {30'd0, e[9:8]});
        check("pulse_data", {24'd0, o_data}, {24'd0, e[7:0]});
      end
    end
  end

  initial begin
    tests = 0;
    failed = 0;
    cyc = 0;
    prev_valid_cyc = 0;
    last_valid_cyc = 0;
    busy_seen = 1'b0;
    i_rx = 1'b1;
    i_reset = 1'b1;
    repeat (3) @(negedge i_clk);
    check("reset_data", {24'd0, o_data}, 32'h00);
    check("reset_valid", {31'd0, o_valid}, 32'd0);
    check("reset_ferr", {31'd0, o_frame_err}, 32'd0);
    check("reset_busy", {31'd0, o_busy}, 32'd0);
    check("reset_state", {29'd0, o_dbg_state}, 32'd0);
    i_reset = 1'b0;
    repeat (4) @(negedge i_clk);

    // Good frame 0xA5
    expect_evt(K_VALID, 8'hA5);
    send_frame(8'hA5, 1'b1, ^8'hA5);
    check("a5_data", {24'd0, o_data}, 32'hA5);
    check("a5_busy_after", {31'd0, o_busy}, 32'd0);

    // Start glitch of 5 cycles
    busy_seen = 1'b0;
    i_rx = 1'b0;
    repeat (5) @(negedge i_clk);
    i_rx = 1'b1;
    repeat (20) @(negedge i_clk);
    check("glitch_busy_seen", {31'd0, busy_seen}, 32'd1);
    check("glitch_state_idle", {29'd0, o_dbg_state}, 32'd0);
    check("glitch_busy_after", {31'd0, o_busy}, 32'd0);
    check("glitch_data_held", {24'd0, o_data}, 32'hA5);

    // Framing error keeps the previous good byte
    expect_evt(K_VALID, 8'h11);
    send_frame(8'h11, 1'b1, ^8'h11);
    expect_evt(K_FERR, 8'h11);
    send_frame(8'h3C, 1'b0, ^8'h3C);
    i_rx = 1'b1;
    repeat (40) @(negedge i_clk);
    check("ferr_data_held", {24'd0, o_data}, 32'h11);
    check("ferr_state_idle", {29'd0, o_dbg_state}, 32'd0);

    // Back-to-back frames, no idle gap
    expect_evt(K_VALID, 8'h00);
    expect_evt(K_VALID, 8'hFF);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    check("b2b_spacing", last_valid_cyc - prev_valid_cyc, 32'd160);
    check("b2b_data", {24'd0, o_data}, 32'hFF);

    // Reset during bit 4 of 0x5A
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(8'h5A >> i);
    i_rx = 1'b0;
    repeat (CPB / 2) @(negedge i_clk);
    i_reset = 1'b1;
    i_rx = 1'b1;
    repeat (2) @(negedge i_clk);
    check("midreset_data", {24'd0, o_data}, 32'h00);
    check("midreset_busy", {31'd0, o_busy}, 32'd0);
    i_reset = 1'b0;
    repeat (4) @(negedge i_clk);
    expect_evt(K_VALID, 8'h81);
    send_frame(8'h81, 1'b1, ^8'h81);
    check("after_reset_data", {24'd0, o_data}, 32'h81);

`ifdef UART_RX_PARITY_EN
    expect_evt(K_VALID, 8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    expect_evt(K_PERR, 8'h07);
    send_frame(8'h07, 1'b1, 1'b0);
    i_rx = 1'b1;
    repeat (8) @(negedge i_clk);
`endif

    // Drain, bounded
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge i_clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    repeat (4) @(negedge i_clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver: the receive-side counterpart of the team's UART transmit path (PISO shift register plus bit-timing FSM).
- Oversamples the asynchronous i_rx line with a cycle counter and samples each bit at mid-bit.
- Assembles LSB-first data and presents one byte per frame with a single-cycle valid strobe.
- Sits between the board RX pin and the command/loopback logic.

Parameters:
- CLKS_PER_BIT, 217, i_clk cycles per bit (25 MHz / 115200); minimum 4.
- DATA_BITS, 8, data bits per frame.

Ports:
- i_clk  input  1  system clock.
- i_reset  input  1  synchronous, active-high reset.
- i_rx  input  1  asynchronous serial line; idle high.
- o_data  output  DATA_BITS  last good received byte; held until the next good frame.
- o_valid  output  1  one-cycle pulse when o_data updates.
- o_frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- o_busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset and clocking: i_clk, with synchronous active-high reset i_reset.
- Reset values:
  - o_data=0, o_valid=0, o_frame_err=0, o_busy=0.
  - FSM=IDLE, counters=0.
  - Both synchronizer flops = 1, so the line reads idle.
- Input synchronization: i_rx passes through a 2-FF synchronizer. All logic uses the synchronized signal (rx_s), which adds 2 cycles of latency.
- Bit counter: width $clog2(CLKS_PER_BIT); it is zeroed on every state change.
- IDLE:
  - rx_s==0 -> START.
  - Otherwise stay.
- START:
  - At count == CLKS_PER_BIT/2 - 1 (integer divide), sample rx_s.
  - Sample 0 -> DATA, with bit index = 0.
  - Sample 1 -> glitch: return to IDLE with no outputs.
- DATA:
  - At count == CLKS_PER_BIT - 1, sample rx_s into shift_reg_sipo. It shifts right, so the first bit ends at bit 0 after DATA_BITS shifts.
  - Increment the index. After the shift for index DATA_BITS-1 -> STOP (or PARITY when enabled).
- STOP:
  - At count == CLKS_PER_BIT - 1, sample rx_s.
  - Sample 1 -> o_data <= shift contents, and o_valid=1 for exactly the next cycle.
  - Sample 0 -> o_frame_err=1 for exactly the next cycle; o_data is unchanged.
  - Either way -> IDLE in the same cycle.
- Timing: sampling occurs at mid-bit, so half a bit of slack remains before the next start edge. Back-to-back frames must be received with no loss.
- Sustained break (line held low): produces a frame error every ~DATA_BITS+2 bit times. This is acceptable.
- Exclusivity: o_valid and o_frame_err are never high in the same cycle.
- Reset mid-frame: aborts immediately and outputs return to their reset values. The partial byte is discarded with no pulses.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - Adds a PARITY state between DATA and STOP (even parity), sampled at count == CLKS_PER_BIT - 1.
  - Adds output port o_parity_err (1 bit, reset 0).
  - At STOP with stop bit = 1: a parity mismatch pulses o_parity_err instead of o_valid, and o_data is not updated.
  - A stop bit of 0 still takes priority and pulses o_frame_err only.
- When undefined: no PARITY state and no port; frame is 8N1.

Decomposition:
- Shared include file uart_defs.vh holds:
  - FSM state localparams: IDLE, START, DATA, PARITY, STOP.
  - Default CLKS_PER_BIT for 25 MHz/115200, shared with the transmitter.
- Natural sub-module: shift_reg_sipo (WIDTH=DATA_BITS, ports i_clk, i_reset, i_shift, i_serial, o_data). It is the serial-in mirror of the existing PISO and goes to shared/lib.

Test Plan (CLKS_PER_BIT=16):
- Frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1 LSB-first, stop 1) -> o_data=0xA5; o_valid high exactly 1 cycle; o_frame_err stays 0; o_busy back to 0 after the frame.
- i_rx low for 5 cycles, then high -> no o_valid or o_frame_err; FSM back in IDLE; o_busy pulses only during the glitch.
- Frame 0x3C with stop bit 0 after prior good byte 0x11 -> o_frame_err 1-cycle pulse; o_data stays 0x11.
- Back-to-back 0x00 then 0xFF with no idle gap -> two o_valid pulses 160 cycles apart; o_data=0x00 then 0xFF.
- i_reset asserted during bit 4 of 0x5A, then frame 0x81 -> no pulse for 0x5A; o_data=0x81 with one o_valid.
- With UART_RX_PARITY_EN: 0x07 with parity bit 1 (correct) -> o_valid. Same byte with parity bit 0 -> o_parity_err pulse, no o_valid.
